// File: rtl/adder_cmp_pkg.sv
// ============================================================================
// Module  : adder_cmp_pkg
// Purpose : Shared types and constants for the adder stimulus/checker slice.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package adder_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam int          ERR_W        = 16;
  localparam int          NUM_CORNERS  = 4;
  localparam logic [15:0] CORNER_ALT_A = 16'h5555;
  localparam logic [15:0] CORNER_ALT_B = 16'hAAAA;

endpackage

`default_nettype wire

// File: rtl/adder_lfsr32.sv
// ============================================================================
// Module  : adder_lfsr32
// Purpose : 32-bit right-shifting Galois LFSR with seed load and advance enable.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module adder_lfsr32
  import adder_cmp_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_1357
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_adv,
  output logic [31:0] o_state
);

  // An all-zero state would lock up, so a zero seed is replaced by 1.
  localparam logic [31:0] C_SEED = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] r_state;
  logic [31:0] w_next;

  assign w_next  = {1'b0, r_state[31:1]} ^ (r_state[0] ? LFSR_TAPS : 32'h0);
  assign o_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_SEED;
    end else if (i_load) begin
      r_state <= C_SEED;
    end else if (i_adv) begin
      r_state <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adder_stim_checker.sv
// ============================================================================
// Module  : adder_stim_checker
// Purpose : Drives A/B/Cin into a pipelined adder and checks Sum/Cout against A+B+Cin.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module adder_stim_checker
  import adder_cmp_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int          LATENCY     = 2,
  parameter int          NUM_VECTORS = 1024,
  parameter logic [31:0] SEED        = 32'hACE1_1357
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      vec_count,
  output logic [15:0]      first_err_idx
);

  localparam logic [15:0] C_LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] C_NO_ERR   = 16'hFFFF;

  state_t           r_state, w_next_state;
  logic [15:0]      r_idx;
  logic [31:0]      w_lfsr;
  logic [WIDTH-1:0] r_a, r_b, w_a, w_b;
  logic             r_cin, w_cin;
  logic             w_launch, w_issue, w_adv, w_pipe_empty, w_cmp, w_mis;
  logic [15:0]      w_issue_idx;
  logic [WIDTH:0]   w_exp;
  logic [WIDTH:0]   r_exp  [LATENCY];
  logic [15:0]      r_pidx [LATENCY];
  logic [LATENCY-1:0] r_vld;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [15:0]      r_vec, r_first;

  assign w_launch     = (r_state == IDLE) && start;
  assign w_issue      = w_launch || (r_state == RUN);
  assign w_issue_idx  = w_launch ? 16'd0 : r_idx;
  assign w_adv        = w_issue && (w_issue_idx >= 16'(NUM_CORNERS));
  assign w_pipe_empty = (r_vld == '0);

  adder_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_launch),
    .i_adv   (w_adv),
    .o_state (w_lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (r_idx == C_LAST_IDX) w_next_state = DRAIN;
      DRAIN:   if (w_pipe_empty) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN) || (r_state == DRAIN);
    done = (r_state == DONE);
  end

  // Four directed corners first, then LFSR-derived operands.
  always_comb begin
    w_a   = w_lfsr[WIDTH-1:0];
    w_b   = w_lfsr[16 +: WIDTH];
    w_cin = w_lfsr[31] ^ w_lfsr[0];
    if (w_issue_idx < 16'(NUM_CORNERS)) begin
      case (w_issue_idx[1:0])
        2'd0:    begin w_a = '0; w_b = '0; w_cin = 1'b0; end
        2'd1:    begin w_a = '1; w_b = '1; w_cin = 1'b1; end
        2'd2:    begin w_a = '1; w_b = '0; w_cin = 1'b1; end
        default: begin w_a = CORNER_ALT_A[WIDTH-1:0]; w_b = CORNER_ALT_B[WIDTH-1:0]; w_cin = 1'b1; end
      endcase
    end
  end

  assign w_exp = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_idx <= '0;
    end else begin
      if (w_issue) begin
        r_a   <= w_a;
        r_b   <= w_b;
        r_cin <= w_cin;
      end
      if (w_launch)               r_idx <= 16'd1;
      else if (r_state == RUN)    r_idx <= r_idx + 16'd1;
    end
  end

  // Expected result travels alongside the DUT so it lines up at the compare edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_exp[k]  <= '0;
        r_pidx[k] <= '0;
      end
    end else begin
      r_vld[0]  <= w_issue;
      r_exp[0]  <= w_exp;
      r_pidx[0] <= w_issue_idx;
      for (int k = 1; k < LATENCY; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_exp[k]  <= r_exp[k-1];
        r_pidx[k] <= r_pidx[k-1];
      end
    end
  end

  assign w_cmp = r_vld[LATENCY-1];
  assign w_mis = ({dut_cout, dut_sum} !== r_exp[LATENCY-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err   <= '0;
      r_vec   <= '0;
      r_first <= C_NO_ERR;
      r_pass  <= 1'b0;
    end else if (w_launch) begin
      r_err   <= '0;
      r_vec   <= '0;
      r_first <= C_NO_ERR;
      r_pass  <= 1'b0;
    end else begin
      if (w_cmp) begin
        r_vec <= r_vec + 16'd1;
        if (w_mis) begin
          if (r_err != '1)        r_err   <= r_err + 1'b1;
          if (r_first == C_NO_ERR) r_first <= r_pidx[LATENCY-1];
        end
      end
      if ((r_state == DRAIN) && w_pipe_empty) r_pass <= (r_err == '0);
    end
  end

  assign A             = r_a;
  assign B             = r_b;
  assign Cin           = r_cin;
  assign pass          = r_pass;
  assign err_count     = r_err;
  assign vec_count     = r_vec;
  assign first_err_idx = r_first;

endmodule

`default_nettype wire

// File: tb/tb_adder_stim_checker.sv
// ============================================================================
// Module  : tb_adder_stim_checker
// Purpose : Randomized-vector bench with an in-bench adder DUT model and reference.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_adder_stim_checker;

  localparam int          N    = 1024;
  localparam int          L    = 2;
  localparam logic [31:0] SEED = 32'hACE1_1357;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A, B, dut_sum;
  logic        Cin, dut_cout, busy, done, pass;
  logic [15:0] err_count, vec_count, first_err_idx;

  always #5 clk = ~clk;

  adder_stim_checker #(.WIDTH(16), .LATENCY(L), .NUM_VECTORS(N), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_count(vec_count), .first_err_idx(first_err_idx)
  );

  // Adder under test: one or two output registers, optional bit-12 stuck-at-0.
  int          dut_regs = 1;
  bit          stuck = 1'b0;
  logic [16:0] d1 = '0, d2 = '0, dsel;
  always @(posedge clk) begin
    d1 <= {1'b0, A} + {1'b0, B} + {16'd0, Cin};
    d2 <= d1;
  end
  assign dsel     = (dut_regs == 2) ? d2 : d1;
  assign dut_sum  = dsel[15:0] & (stuck ? 16'hEFFF : 16'hFFFF);
  assign dut_cout = dsel[16];

  // Reference vector list built from the stimulus rules.
  logic [15:0] va [N];
  logic [15:0] vb [N];
  logic        vc [N];
  int          ve [N];
  int          bit12_cnt, bit12_first;

  int n_pass = 0, n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_once(input int extra_start_at, input int abort_at,
                          output int lat, output int n_done, output int vec_bad,
                          output logic busy_early);
    lat = -1; n_done = 0; vec_bad = 0; busy_early = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= N + L + 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        busy_early = busy;
      end
      if (k == extra_start_at)     start = 1'b1;
      if (k == extra_start_at + 1) start = 1'b0;
      if (k == abort_at)           rst = 1'b1;
      if (k == abort_at + 3)       rst = 1'b0;
      if (k <= N && !rst && (abort_at < 0 || k < abort_at)) begin
        if (A !== va[k-1] || B !== vb[k-1] || Cin !== vc[k-1]) vec_bad++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (lat < 0) lat = k;  // done is sampled by the k-th rising edge after start
      end
    end
  endtask

  int   lat, nd, vbad;
  logic be;

  initial begin
    logic [31:0] s;
    s = (SEED == 0) ? 32'h1 : SEED;
    bit12_cnt = 0; bit12_first = -1;
    for (int i = 0; i < N; i++) begin
      case (i)
        0:       begin va[i] = 16'h0000; vb[i] = 16'h0000; vc[i] = 1'b0; end
        1:       begin va[i] = 16'hFFFF; vb[i] = 16'hFFFF; vc[i] = 1'b1; end
        2:       begin va[i] = 16'hFFFF; vb[i] = 16'h0000; vc[i] = 1'b1; end
        3:       begin va[i] = 16'h5555; vb[i] = 16'hAAAA; vc[i] = 1'b1; end
        default: begin
          va[i] = s[15:0]; vb[i] = s[31:16]; vc[i] = s[31] ^ s[0];
          s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        end
      endcase
      ve[i] = int'(va[i]) + int'(vb[i]) + int'(vc[i]);
      if (ve[i][12]) begin
        bit12_cnt++;
        if (bit12_first < 0) bit12_first = i;
      end
    end

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_A", 32'(A), 0);
    chk("rst_busy_done_pass", {29'd0, busy, done, pass}, 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_vec", 32'(vec_count), 0);
    chk("rst_first", 32'(first_err_idx), 32'hFFFF);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (20) begin @(negedge clk); if (done === 1'b1) nd++; end
    chk("idle_no_done", nd, 0);

    // Ideal DUT
    run_once(-1, -1, lat, nd, vbad, be);
    chk("ideal_busy", {31'd0, be}, 1);
    chk("ideal_vectors", vbad, 0);
    chk("ideal_done_lat", lat, N + L + 1);
    chk("ideal_ndone", nd, 1);
    chk("ideal_pass", {31'd0, pass}, 1);
    chk("ideal_err", 32'(err_count), 0);
    chk("ideal_vec", 32'(vec_count), N);
    chk("ideal_first", 32'(first_err_idx), 32'hFFFF);

    // Asynchronous reset mid-clock
    @(posedge clk); #2 rst = 1'b1; #1;
    chk("async_vec", 32'(vec_count), 0);
    chk("async_pass_A", {15'd0, pass, A}, 0);
    chk("async_first", 32'(first_err_idx), 32'hFFFF);
    @(negedge clk); rst = 1'b0;

    // Stuck-at bit 12
    stuck = 1'b1;
    run_once(-1, -1, lat, nd, vbad, be);
    stuck = 1'b0;
    chk("stuck_pass", {31'd0, pass}, 0);
    chk("stuck_err", 32'(err_count), bit12_cnt);
    chk("stuck_first", 32'(first_err_idx), bit12_first);
    chk("stuck_first_is_1", 32'(first_err_idx), 1);

    // DUT one stage deeper than LATENCY
    dut_regs = 2;
    run_once(-1, -1, lat, nd, vbad, be);
    dut_regs = 1;
    chk("lat_pass", {31'd0, pass}, 0);
    chk("lat_err_nonzero", {31'd0, (err_count != 0)}, 1);
    chk("lat_first_le1", {31'd0, (first_err_idx <= 16'd1)}, 1);
    chk("lat_done_lat", lat, N + L + 1);

    // Start pulsed while busy
    run_once(100, -1, lat, nd, vbad, be);
    chk("busy_start_ndone", nd, 1);
    chk("busy_start_vec", 32'(vec_count), N);
    chk("busy_start_pass", {31'd0, pass}, 1);

    // Reset mid-run, then a clean restart
    run_once(-1, 500, lat, nd, vbad, be);
    chk("abort_ndone", nd, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    run_once(-1, -1, lat, nd, vbad, be);
    chk("rerun_vectors", vbad, 0);
    chk("rerun_pass", {31'd0, pass}, 1);
    chk("rerun_vec", 32'(vec_count), N);
    chk("rerun_lat", lat, N + L + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
